// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the instruction-fetch slice.
//   fetch_state_e    : fetch FSM encoding (IDLE, FETCH, DELIVER)
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   IMM_* / TARGET_* : bit positions of the I-type immediate and J-type index
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    localparam int IMM_LSB    = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;
    localparam int TARGET_LSB = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_W   = TARGET_MSB - TARGET_LSB + 1;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection.
//   pc_i             : current PC
//   branch_imm_ext_i : sign-extended branch offset in words
//   jump_target_i    : J-type instruction index
//   branch_taken_i   : select branch target
//   jump_i           : select jump target (wins over branch)
//   pc_plus4_o       : pc_i + 4 (wraps)
//   next_pc_o        : selected next PC
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0]         pc_i,
    input  logic [31:0]         branch_imm_ext_i,
    input  logic [TARGET_W-1:0] jump_target_i,
    input  logic                branch_taken_i,
    input  logic                jump_i,
    output logic [31:0]         pc_plus4_o,
    output logic [31:0]         next_pc_o
);

    logic [31:0] br_target;
    logic [31:0] jmp_target;

    // All sums are 32 bits wide so carries out of bit 31 simply drop.
    assign pc_plus4_o = pc_i + 32'd4;
    assign br_target  = pc_plus4_o + {branch_imm_ext_i[29:0], 2'b00};
    assign jmp_target = {pc_plus4_o[31:28], jump_target_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_i)
            next_pc_o = jmp_target;
        else if (branch_taken_i)
            next_pc_o = br_target;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//   clk, reset           : clock, synchronous active-high reset
//   imem_req/imem_addr   : fetch request and address (= PC)
//   imem_ack/imem_rdata  : memory response
//   stall                : downstream holds the delivered instruction
//   branch_taken/branch_imm_ext, jump/jump_target : redirect, sampled only
//                          when a delivered instruction is consumed
//   instr_valid/instr/imm16/pc_out/pc_plus4 : delivered instruction
// Optional: define IFETCH_STALL_CNT_EN to add stall_cycles, a saturating
// count of FETCH-without-ack and DELIVER-with-stall cycles.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm_ext,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;

    pc_next_calc u_pc_next (
        .pc_i             (pc_q),
        .branch_imm_ext_i (branch_imm_ext),
        .jump_target_i    (jump_target),
        .branch_taken_i   (branch_taken),
        .jump_i           (jump),
        .pc_plus4_o       (pc_plus4),
        .next_pc_o        (next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                instr_valid = 1'b1;
                // PC advances only as the instruction is consumed, so the
                // redirect inputs matter in this one cycle alone.
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign instr     = instr_q;
    assign imm16     = instr_q[IMM_MSB:IMM_LSB];

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = ((state_q == ST_FETCH) && !imem_ack) ||
                       ((state_q == ST_DELIVER) && stall);

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= 32'h0;
        else if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_imm_ext;
    logic        jump;
    logic [25:0] jump_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_imm_ext (branch_imm_ext),
        .jump           (jump),
        .jump_target    (jump_target),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .imm16          (imm16),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard queues
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    // observations collected by drive_fetch
    logic        obs_timeout;
    logic [31:0] obs_addr;
    int          obs_req_cnt;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc;
    logic [31:0] obs_pc4;
    logic [15:0] obs_imm16;
    int          obs_valid_cyc;
    logic        obs_stable;
    logic        obs_after_valid;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One fetch/deliver round trip. Spurious jumps during FETCH and stall,
    // and acks during stall, must all be ignored by the DUT.
    task automatic drive_fetch(input int wait_n, input int stall_n, input logic [31:0] rdata,
                               input logic br, input logic [31:0] imm,
                               input logic jmp, input logic [25:0] tgt);
        int guard;
        guard = 0;
        obs_timeout = 1'b0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (imem_req !== 1'b1) begin
            obs_timeout = 1'b1;
            return;
        end
        obs_addr    = imem_addr;
        obs_req_cnt = 0;
        for (int i = 0; i <= wait_n; i++) begin
            if (imem_req === 1'b1) obs_req_cnt++;
            jump        = 1'b1;
            jump_target = 26'h3FF_FFFF;
            imem_ack    = (i == wait_n);
            imem_rdata  = (i == wait_n) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        imem_ack      = 1'b0;
        obs_valid     = instr_valid;
        obs_instr     = instr;
        obs_pc        = pc_out;
        obs_pc4       = pc_plus4;
        obs_imm16     = imm16;
        obs_valid_cyc = cyc;
        obs_stable    = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
            stall      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            if (instr !== obs_instr || instr_valid !== 1'b1 || pc_out !== obs_pc)
                obs_stable = 1'b0;
        end
        imem_ack       = 1'b0;
        stall          = 1'b0;
        branch_taken   = br;
        branch_imm_ext = imm;
        jump           = jmp;
        jump_target    = tgt;
        @(negedge clk);
        obs_after_valid = instr_valid;
        branch_taken    = 1'b0;
        jump            = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_checks++;
        if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
        n_checks++;
        if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=00400000", pc_out); end
`ifdef IFETCH_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cycles); end
`endif
        reset = 1'b0; imem_ack = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
            n_fail++; $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=00400000", imem_req, imem_addr);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] ea, ei;
        exp_addr_q.push_back(32'h0040_0000);
        exp_instr_q.push_back(32'h2008_0005);
        drive_fetch(0, 0, 32'h2008_0005, 1'b0, 32'h0, 1'b0, 26'h0);
        ea = exp_addr_q.pop_front();
        ei = exp_instr_q.pop_front();
        n_checks++;
        if (obs_timeout) begin n_fail++; $display("FAIL first_timeout no imem_req"); end
        n_checks++;
        if (obs_addr !== ea) begin n_fail++; $display("FAIL first_addr got=%h exp=%h", obs_addr, ea); end
        n_checks++;
        if (obs_valid !== 1'b1 || obs_instr !== ei) begin
            n_fail++; $display("FAIL first_instr got valid=%b instr=%h exp valid=1 instr=%h", obs_valid, obs_instr, ei);
        end
        n_checks++;
        if (obs_imm16 !== 16'h0005) begin n_fail++; $display("FAIL first_imm16 got=%h exp=0005", obs_imm16); end
        n_checks++;
        if (obs_pc !== 32'h0040_0000 || obs_pc4 !== 32'h0040_0004) begin
            n_fail++; $display("FAIL first_pc got pc=%h pc4=%h exp 00400000/00400004", obs_pc, obs_pc4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ea;
        int prev_cyc;
        do_reset();
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            exp_addr_q.push_back(32'h0040_0000 + 32'(4 * k));
            drive_fetch(0, 0, 32'h0000_1000 + 32'(k), 1'b0, 32'h0, 1'b0, 26'h0);
            ea = exp_addr_q.pop_front();
            n_checks++;
            if (obs_timeout || obs_addr !== ea) begin
                n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h timeout=%b", k, obs_addr, ea, obs_timeout);
            end
            n_checks++;
            if (obs_valid !== 1'b1 || obs_after_valid !== 1'b0) begin
                n_fail++; $display("FAIL seq_pulse[%0d] got valid=%b after=%b exp 1/0", k, obs_valid, obs_after_valid);
            end
            if (k > 0) begin
                n_checks++;
                if (obs_valid_cyc - prev_cyc != 2) begin
                    n_fail++; $display("FAIL seq_rate[%0d] got=%0d exp=2 cycles", k, obs_valid_cyc - prev_cyc);
                end
            end
            prev_cyc = obs_valid_cyc;
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] tbl_addr [10];
        logic        tbl_br   [10];
        logic        tbl_jmp  [10];
        logic [31:0] ea;
        tbl_addr = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010,
                     32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010, 32'h0040_000C};
        tbl_br   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl_jmp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            exp_addr_q.push_back(tbl_addr[k]);
            drive_fetch(0, 0, 32'h1000_0000 + 32'(k), tbl_br[k], 32'hFFFF_FFFC, tbl_jmp[k], 26'h010_0003);
            ea = exp_addr_q.pop_front();
            n_checks++;
            if (obs_timeout || obs_addr !== ea) begin
                n_fail++; $display("FAIL redirect_addr[%0d] got=%h exp=%h timeout=%b", k, obs_addr, ea, obs_timeout);
            end
        end
    endtask

    task automatic test_wait_stall();
        logic [31:0] ei;
        do_reset();
        exp_instr_q.push_back(32'h8C42_0004);
        drive_fetch(3, 2, 32'h8C42_0004, 1'b0, 32'h0, 1'b0, 26'h0);
        ei = exp_instr_q.pop_front();
        n_checks++;
        if (obs_timeout || obs_req_cnt != 4) begin
            n_fail++; $display("FAIL wait_req_cycles got=%0d exp=4 timeout=%b", obs_req_cnt, obs_timeout);
        end
        n_checks++;
        if (obs_instr !== ei) begin n_fail++; $display("FAIL wait_instr got=%h exp=%h", obs_instr, ei); end
        n_checks++;
        if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable got=%b exp=1", obs_stable); end
        n_checks++;
        if (imem_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL stall_next_addr got=%h exp=00400004", imem_addr); end
`ifdef IFETCH_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", stall_cycles); end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        logic seen_valid;
        do_reset();
        drive_fetch(0, 0, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 26'h0);
        // now in FETCH for 0x00400004
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_drop got req=%b valid=%b exp 0/0", imem_req, instr_valid);
        end
        n_checks++;
        if (instr !== 32'h0) begin n_fail++; $display("FAIL midreset_instr got=%h exp=0", instr); end
        reset = 1'b0; imem_ack = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (instr_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid) begin n_fail++; $display("FAIL midreset_valid got=1 exp=0"); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
            n_fail++; $display("FAIL midreset_refetch got req=%b addr=%h exp 1/00400000", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        // 0x00400004 + (0xFFEFFFFE << 2) = 0xFFFFFFFC modulo 2^32
        drive_fetch(0, 0, 32'h0000_0002, 1'b1, 32'hFFEF_FFFE, 1'b0, 26'h0);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        drive_fetch(0, 0, 32'h0000_0003, 1'b0, 32'h0, 1'b0, 26'h0);
        n_checks++;
        if (obs_timeout || obs_addr !== exp_addr_q[0]) begin
            n_fail++; $display("FAIL wrap_branch_addr got=%h exp=%h", obs_addr, exp_addr_q[0]);
        end
        void'(exp_addr_q.pop_front());
        n_checks++;
        if (obs_pc4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=0", obs_pc4); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_next_addr got req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_imm_ext = 32'h0; jump = 1'b0; jump_target = 26'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch_jump();
        test_wait_stall();
        test_reset_mid_fetch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
